// File: rtl/fanin_link_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_en
// Brief    : Shared types and constants for the fan-in link arbiter.
//            arb_state_t  - arbiter state encoding (IDLE/HEAD/XFER/GAP)
//            WIDTH_LENGTH - default width of the message-length field
//            wrap_inc()   - modulo-n increment used for the rotating pointer
// Revision : 1.0 - initial release
// ============================================================================
package pkg_en;

  localparam int WIDTH_LENGTH = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  // Next link index after idx, wrapping to 0 at n (n need not be a power of 2).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fanin_link_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotating priority pick. Returns the first set bit
//            of i_req at or after i_ptr, searching upward and wrapping.
// Ports    : i_req       - request vector
//            i_ptr       - index with highest priority this cycle
//            o_grant_oh  - one-hot winner (all zero if no request)
//            o_grant_idx - encoded winner (0 if no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import pkg_en::*;
#(
  parameter int NUM_LINK = 4,
  parameter int SEL_W    = $clog2(NUM_LINK)
) (
  input  logic [NUM_LINK-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic [NUM_LINK-1:0] o_grant_oh,
  output logic [SEL_W-1:0]    o_grant_idx
);

  logic             w_found;
  logic [SEL_W-1:0] w_cand;

  // Walk the links in priority order; the modulo keeps the walk inside
  // 0..NUM_LINK-1 even when NUM_LINK is not a power of two.
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int off = 0; off < NUM_LINK; off++) begin
      w_cand = SEL_W'((int'(i_ptr) + off) % NUM_LINK);
      if (!w_found && i_req[w_cand]) begin
        w_found             = 1'b1;
        o_grant_oh[w_cand]  = 1'b1;
        o_grant_idx         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fanin_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fanin_link_arbiter
// Brief    : Round-robin, message-locked arbiter sharing one output channel
//            among NUM_LINK links. A grant is held from the header token to
//            the release token or until the header length count runs out.
// Ports    : clock, reset - clock and synchronous active-high reset
//            I_Req  - per-link token valid
//            I_Rls  - per-link "last token of message"
//            I_Len  - per-link header length (0 = unbounded), header only
//            I_Nack - downstream back-pressure on the shared channel
//            O_Grt  - one-hot grant (zero when idle)
//            O_Sel  - encoded granted link
//            O_Nack - per-link nack (losers always nacked)
//            O_Busy - grant held
//            O_Remain - remaining token count of current message
// Revision : 1.0 - initial release
// ============================================================================
module fanin_link_arbiter
  import pkg_en::*;
#(
  parameter int NUM_LINK     = 4,
  parameter int WIDTH_LENGTH = pkg_en::WIDTH_LENGTH,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_LINK-1:0]              I_Req,
  input  logic [NUM_LINK-1:0]              I_Rls,
  input  logic [NUM_LINK*WIDTH_LENGTH-1:0] I_Len,
  input  logic                             I_Nack,
  output logic [NUM_LINK-1:0]              O_Grt,
  output logic [$clog2(NUM_LINK)-1:0]      O_Sel,
  output logic [NUM_LINK-1:0]              O_Nack,
  output logic                             O_Busy,
  output logic [WIDTH_LENGTH-1:0]          O_Remain
);

  localparam int                      SEL_W      = $clog2(NUM_LINK);
  localparam logic [1:0]              c_gap_load = 2'(GAP_CYCLES);
  localparam logic [WIDTH_LENGTH-1:0] c_len_one  = WIDTH_LENGTH'(1);

  // Registered state
  arb_state_t              r_state;
  logic [NUM_LINK-1:0]     r_grt;
  logic [SEL_W-1:0]        r_sel;
  logic                    r_busy;
  logic [WIDTH_LENGTH-1:0] r_remain;
  logic [SEL_W-1:0]        r_ptr;
  logic [1:0]              r_gap_cnt;

  // Next-state values
  arb_state_t              w_state_nxt;
  logic [NUM_LINK-1:0]     w_grt_nxt;
  logic [SEL_W-1:0]        w_sel_nxt;
  logic                    w_busy_nxt;
  logic [WIDTH_LENGTH-1:0] w_remain_nxt;
  logic [SEL_W-1:0]        w_ptr_nxt;
  logic [1:0]              w_gap_nxt;
  logic                    w_release;
  logic                    w_arb_en;

  // Datapath helpers
  logic                    w_xfer;
  logic                    w_rls_sel;
  logic [WIDTH_LENGTH-1:0] w_len_sel;
  logic [SEL_W-1:0]        w_rel_ptr;
  logic [SEL_W-1:0]        w_pick_ptr;
  logic [NUM_LINK-1:0]     w_pick_oh;
  logic [SEL_W-1:0]        w_pick_idx;

  assign w_xfer    = (|(r_grt & I_Req)) & ~I_Nack;
  assign w_rls_sel = I_Rls[r_sel];
  assign w_len_sel = I_Len[r_sel*WIDTH_LENGTH +: WIDTH_LENGTH];
  assign w_rel_ptr = SEL_W'(wrap_inc(int'(r_sel), NUM_LINK));

  // While a message is active the only arbitration that can happen this
  // cycle is the zero-gap re-arbitration on release, which must already
  // see the advanced pointer.
  assign w_pick_ptr = ((r_state == IDLE) || (r_state == GAP)) ? r_ptr : w_rel_ptr;

  rr_pick #(
    .NUM_LINK (NUM_LINK),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .i_req       (I_Req),
    .i_ptr       (w_pick_ptr),
    .o_grant_oh  (w_pick_oh),
    .o_grant_idx (w_pick_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_grt_nxt    = r_grt;
    w_sel_nxt    = r_sel;
    w_busy_nxt   = r_busy;
    w_remain_nxt = r_remain;
    w_ptr_nxt    = r_ptr;
    w_gap_nxt    = r_gap_cnt;
    w_release    = 1'b0;
    w_arb_en     = 1'b0;

    case (r_state)
      IDLE: w_arb_en = 1'b1;

      HEAD: begin
        if (w_xfer) begin
          w_remain_nxt = w_len_sel;
          if (w_rls_sel || (w_len_sel == c_len_one)) begin
            w_release = 1'b1;
          end else begin
            w_state_nxt = XFER;
          end
        end
      end

      XFER: begin
        if (w_xfer) begin
          // A zero counter means an unbounded message; it never wraps.
          if (r_remain != '0) begin
            w_remain_nxt = r_remain - c_len_one;
          end
          if (w_rls_sel || (r_remain == c_len_one)) begin
            w_release = 1'b1;
          end
        end
      end

      GAP: begin
        // The last gap cycle doubles as the arbitration cycle, so exactly
        // GAP_CYCLES grant-free cycles separate consecutive messages.
        if (r_gap_cnt <= 2'd1) begin
          w_state_nxt = IDLE;
          w_arb_en    = 1'b1;
        end else begin
          w_gap_nxt = r_gap_cnt - 2'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (w_release) begin
      w_grt_nxt    = '0;
      w_busy_nxt   = 1'b0;
      w_remain_nxt = '0;
      w_ptr_nxt    = w_rel_ptr;
      if (GAP_CYCLES == 0) begin
        w_state_nxt = IDLE;
        w_arb_en    = 1'b1;
      end else begin
        w_state_nxt = GAP;
        w_gap_nxt   = c_gap_load;
      end
    end

    if (w_arb_en && (|I_Req)) begin
      w_grt_nxt   = w_pick_oh;
      w_sel_nxt   = w_pick_idx;
      w_busy_nxt  = 1'b1;
      w_state_nxt = HEAD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grt     <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_remain  <= '0;
      r_ptr     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grt     <= w_grt_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_remain  <= w_remain_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Losing links are always back-pressured; the owner sees the channel nack.
  for (genvar l = 0; l < NUM_LINK; l++) begin : g_nack
    assign O_Nack[l] = r_grt[l] ? I_Nack : 1'b1;
  end

  assign O_Grt    = r_grt;
  assign O_Sel    = r_sel;
  assign O_Busy   = r_busy;
  assign O_Remain = r_remain;

endmodule
`default_nettype wire

// File: tb/tb_fanin_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fanin_link_arbiter
// Brief    : Self-checking bench for fanin_link_arbiter with a transaction-
//            level reference model (owner / token count / pointer / wait).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fanin_link_arbiter;

  localparam int NL  = 4;
  localparam int WL  = 10;
  localparam int GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NL-1:0]    req;
  logic [NL-1:0]    rls;
  logic [NL*WL-1:0] len;
  logic             nack;

  logic [NL-1:0]    O_Grt;
  logic [1:0]       O_Sel;
  logic [NL-1:0]    O_Nack;
  logic             O_Busy;
  logic [WL-1:0]    O_Remain;

  fanin_link_arbiter #(
    .NUM_LINK     (NL),
    .WIDTH_LENGTH (WL),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .I_Req    (req),
    .I_Rls    (rls),
    .I_Len    (len),
    .I_Nack   (nack),
    .O_Grt    (O_Grt),
    .O_Sel    (O_Sel),
    .O_Nack   (O_Nack),
    .O_Busy   (O_Busy),
    .O_Remain (O_Remain)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who owns the channel, how many tokens it has moved,
  // the remaining count, the round-robin pointer and grant-free cycles left.
  int m_owner = -1;
  int m_sel   = 0;
  int m_tok   = 0;
  int m_remain = 0;
  int m_ptr   = 0;
  int m_wait  = 0;

  logic [20:0] dut_vec;
  assign dut_vec = {O_Grt, O_Sel, O_Busy, O_Remain, O_Nack};

  function automatic int lenv(input int l);
    return int'(len[l*WL +: WL]);
  endfunction

  task automatic set_len(input int l, input int v);
    len[l*WL +: WL] = WL'(v);
  endtask

  function automatic logic [20:0] exp_vec();
    logic [NL-1:0] g;
    logic [NL-1:0] n;
    g = '0;
    n = '1;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      n[m_owner] = nack;
    end
    return {g, 2'(m_sel), (m_owner >= 0), 10'(m_remain), n};
  endfunction

  task automatic model_arb();
    for (int k = 0; k < NL; k++) begin
      int c;
      c = (m_ptr + k) % NL;
      if (req[c]) begin
        m_owner = c;
        m_sel   = c;
        m_tok   = 0;
        break;
      end
    end
  endtask

  task automatic model_edge();
    bit last;
    int l;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_tok = 0; m_remain = 0; m_ptr = 0; m_wait = 0;
      return;
    end
    if (m_owner >= 0) begin
      if (req[m_owner] && !nack) begin
        l = lenv(m_owner);
        if (m_tok == 0) begin
          last     = rls[m_owner] || (l == 1);
          m_remain = l;
        end else begin
          last = rls[m_owner] || (m_remain == 1);
          if (m_remain > 0) m_remain = m_remain - 1;
        end
        m_tok = m_tok + 1;
        if (last) begin
          m_ptr    = (m_owner + 1) % NL;
          m_owner  = -1;
          m_remain = 0;
          m_wait   = GAP;
          if (m_wait == 0) model_arb();
        end
      end
    end else if (m_wait > 1) begin
      m_wait = m_wait - 1;
    end else begin
      m_wait = 0;
      model_arb();
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rls = '0; nack = 1'b0; len = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; rls = 4'b0101; nack = 1'b0; len = '1;
    tick();
    tick();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
    end
    checks++;
    if (dut_vec !== {4'b0000, 2'd0, 1'b0, 10'd0, 4'b1111}) begin
      errors++; $display("FAIL reset_values got=%h want=%h", dut_vec, {4'b0000, 2'd0, 1'b0, 10'd0, 4'b1111});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [9:0] rem_q[$];
    bit granted = 0;
    bit done = 0;
    logic [9:0] want[4] = '{10'd0, 10'd3, 10'd2, 10'd1};
    do_reset();
    req = 4'b0100;
    set_len(2, 3);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL single cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (O_Grt !== 4'b0100 || O_Sel !== 2'd2) begin
          errors++; $display("FAIL single_latency grt=%b sel=%0d want 0100/2", O_Grt, O_Sel);
        end
      end
      if (O_Grt[2]) granted = 1;
      if (granted && !O_Grt[2]) done = 1;
      if (!done && O_Grt[2] && !nack) rem_q.push_back(O_Remain);
      if (done) req = '0;
      tick();
    end
    // Header transfer sees an empty counter, then three counted tokens 3,2,1.
    checks++;
    if (rem_q.size() != 4) begin
      errors++; $display("FAIL single_count got=%0d want=4", rem_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rem_q[k] !== want[k]) begin
          errors++; $display("FAIL single_remain idx=%0d got=%0d want=%0d", k, rem_q[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int order[$];
    int gaps[$];
    int low = 0;
    bit prev = 0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      rls = (m_owner >= 0 && m_tok == 1) ? 4'b1111 : 4'b0000;
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL contention cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (|O_Grt) begin
        checks++;
        if ((O_Nack | O_Grt) !== 4'b1111) begin
          errors++; $display("FAIL contention_losers nack=%b grt=%b", O_Nack, O_Grt);
        end
      end
      if ((|O_Grt) && !prev) begin
        order.push_back(int'(O_Sel));
        if (order.size() > 1) gaps.push_back(low);
      end
      if (|O_Grt) low = 0; else low++;
      prev = |O_Grt;
      tick();
    end
    req = '0; rls = '0;
    checks++;
    if (order.size() < 5) begin
      errors++; $display("FAIL contention_grants got=%0d want>=5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (order[k] != exp_order[k]) begin
          errors++; $display("FAIL contention_order idx=%0d got=%0d want=%0d", k, order[k], exp_order[k]);
        end
      end
    end
    foreach (gaps[k]) begin
      checks++;
      if (gaps[k] != GAP) begin
        errors++; $display("FAIL contention_gap idx=%0d got=%0d want=%0d", k, gaps[k], GAP);
      end
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    do_reset();
    req = 4'b0010;
    set_len(1, 4);
    for (int i = 0; i < 14; i++) begin
      nack = (i >= 3 && i <= 7);
      if (i >= 11) req = '0;
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL backpressure cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (i >= 3 && i <= 7) begin
        checks++;
        if (O_Remain !== 10'd3 || O_Grt !== 4'b0010 || O_Nack !== 4'b1111) begin
          errors++; $display("FAIL backpressure_stall i=%0d rem=%0d grt=%b nack=%b want 3/0010/1111", i, O_Remain, O_Grt, O_Nack);
        end
      end
      if (O_Grt[1] && req[1] && !nack) xfers++;
      tick();
    end
    nack = 1'b0;
    checks++;
    if (xfers != 5) begin
      errors++; $display("FAIL backpressure_xfers got=%0d want=5", xfers);
    end
  endtask

  task automatic test_unbounded();
    int xfers = 0;
    do_reset();
    req = 4'b0001;
    set_len(0, 0);
    for (int i = 0; i < 14; i++) begin
      rls = (m_owner == 0 && m_tok == 6) ? 4'b0001 : 4'b0000;
      if (i >= 8) req = '0;
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL unbounded cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (O_Grt[0]) begin
        checks++;
        if (O_Remain !== 10'd0) begin
          errors++; $display("FAIL unbounded_remain i=%0d got=%0d want=0", i, O_Remain);
        end
        if (req[0] && !nack) xfers++;
      end
      tick();
    end
    rls = '0;
    checks++;
    if (xfers != 7) begin
      errors++; $display("FAIL unbounded_xfers got=%0d want=7", xfers);
    end
  endtask

  task automatic test_boundaries();
    int xfers;
    bit granted;
    // Header carrying both release and length 1.
    do_reset();
    req = 4'b1000; rls = 4'b1000; set_len(3, 1);
    xfers = 0; granted = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL bound_single cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (O_Grt[3]) granted = 1;
      if (granted && !O_Grt[3]) req = '0;
      if (O_Grt[3] && req[3] && !nack) xfers++;
      tick();
    end
    checks++;
    if (xfers != 1) begin
      errors++; $display("FAIL bound_single_xfers got=%0d want=1", xfers);
    end
    // Release together with the last counted token.
    do_reset();
    req = 4'b1000; set_len(3, 2);
    xfers = 0; granted = 0;
    for (int i = 0; i < 8; i++) begin
      rls = (m_owner == 3 && m_tok > 0 && m_remain == 1) ? 4'b1000 : 4'b0000;
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL bound_rls_cnt cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (O_Grt[3]) granted = 1;
      if (granted && !O_Grt[3]) req = '0;
      if (O_Grt[3] && req[3] && !nack) xfers++;
      tick();
    end
    rls = '0;
    checks++;
    if (xfers != 3) begin
      errors++; $display("FAIL bound_rls_cnt_xfers got=%0d want=3", xfers);
    end
    // Pointer wrap: link 2 finishes, pointer sits at 3, only link 0 asks.
    do_reset();
    req = 4'b0100; rls = 4'b0100; set_len(2, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin req = 4'b0001; rls = '0; end
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL bound_wrap cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (i == 3) begin
        checks++;
        if (O_Grt !== 4'b0001 || O_Sel !== 2'd0) begin
          errors++; $display("FAIL bound_wrap_grant grt=%b sel=%0d want 0001/0", O_Grt, O_Sel);
        end
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_reset_midxfer();
    do_reset();
    req = 4'b0010;
    set_len(1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL midreset_pre cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      tick();
    end
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if (O_Grt !== 4'b0000 || O_Nack !== 4'b1111 || O_Busy !== 1'b0 || O_Remain !== 10'd0) begin
      errors++; $display("FAIL midreset_abort grt=%b nack=%b busy=%b rem=%0d", O_Grt, O_Nack, O_Busy, O_Remain);
    end
    rst = 1'b0;
    req = 4'b1111;
    tick();
    #1;
    checks++;
    if (O_Grt !== 4'b0001 || O_Sel !== 2'd0) begin
      errors++; $display("FAIL midreset_priority grt=%b sel=%0d want 0001/0", O_Grt, O_Sel);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL midreset_model cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      req  = 4'($urandom) | 4'($urandom);
      nack = ($urandom_range(0, 3) == 0);
      for (int l = 0; l < NL; l++) begin
        rls[l] = ($urandom_range(0, 5) == 0);
        set_len(l, $urandom_range(0, 4));
      end
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d dut=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      tick();
    end
    req = '0; rls = '0; nack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; rls = '0; len = '0; nack = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_unbounded();
    test_boundaries();
    test_reset_midxfer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
